seq_table_fsm: RTL and testbench
================================

Name: seq_table_fsm

Overview:
- Parametrised, programmable sequence generator. Next generation of the team's fixed 8-state sequence FSM.
- Steps through a writable table of WIDTH-bit codes instead of a hard-coded state order.
- Supports programmable length, up/down direction, enable/pause, free-run or one-shot mode, and start/stop control.
- Drives downstream pattern/display logic; seq_out is the code presented each cycle.

Parameters:
WIDTH, 3, bit width of each sequence code and of seq_out
DEPTH, 8, number of table entries (2..256)
IDX_W, clog2(DEPTH) (min 1), index width, derived, not overridden

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  pulse: begin a run from IDLE, or restart while in RUN
stop  input  1  pulse: abort run, return to IDLE
en  input  1  step enable in RUN; 0 = hold current index
dir  input  1  0 = ascending index, 1 = descending index
mode  input  1  0 = free-run (wrap forever), 1 = one-shot; sampled at start
len  input  IDX_W+1  active entries; 0 or >DEPTH means DEPTH; sampled at start
wr_en  input  1  table write strobe
wr_addr  input  IDX_W  table write address
wr_data  input  WIDTH  table write data
seq_out  output  WIDTH  table[idx], combinational read of table registers
seq_idx  output  IDX_W  current index
busy  output  1  1 while in RUN
wrap  output  1  one-cycle pulse, registered, on each free-run wrap
done  output  1  one-cycle pulse, registered, on one-shot completion

Behaviour:
- Reset (rst=0, asynchronous):
  - table[i] = i mod 2^WIDTH; idx=0; state=IDLE; len_q=DEPTH; mode_q=0.
  - Outputs: busy=0, wrap=0, done=0, seq_idx=0, seq_out=0.
- States: IDLE, RUN.
- Priority in any state: stop > start > step.
- IDLE:
  - start=1 -> RUN next edge.
  - On that edge: len_q <= clamped len; mode_q <= mode; idx <= (dir ? len_q_new-1 : 0).
  - Otherwise idx is held and seq_out continues to show table[idx].
- RUN, en=0: hold idx. Not a step; no wrap/done.
- RUN, en=1, normal step: idx +1 (dir=0) or -1 (dir=1).
- RUN, en=1, terminal index (idx==len_q-1 with dir=0, or idx==0 with dir=1):
  - mode_q=0: idx wraps to 0 (dir=0) or len_q-1 (dir=1); wrap=1 next cycle.
  - mode_q=1: idx held; state -> IDLE; done=1 next cycle; busy=0 next cycle.
- RUN, start=1 (stop=0): restart; same sampling as start from IDLE; no wrap/done.
- stop=1 in RUN: -> IDLE; idx held; no done. stop in IDLE: no effect.
- dir may change mid-run; it applies to the next step and to the terminal test of that step.
- len_q=1: every enabled step is terminal.
  - Free-run: wrap pulses every enabled cycle.
  - One-shot: done one cycle after the first enabled RUN cycle.
- Index arithmetic is modulo len_q, never modulo 2^IDX_W.
- Table write: on the clk edge when wr_en=1 and wr_addr<DEPTH; ignored otherwise.
  - Writes are allowed in any state.
  - A write to the current idx is visible on seq_out the next cycle.
- One-shot latency: from the start edge, len_q enabled cycles present all entries; done asserts the cycle after the last entry's step.
- Reset asserted mid-run: immediate return to reset values, including the table.

Test Plan:
- Reset, then observe outputs with no other stimulus -> seq_out=0, seq_idx=0, busy=0, wrap=0, done=0.
- Write table 0,4,1,3,6,2,7,5; start with mode=0, dir=0, len=0, en=1 -> seq_out 0,4,1,3,6,2,7,5,0,... repeating; wrap pulses on the cycle seq_idx returns to 0; busy=1 throughout.
- Same table, mode=1, dir=1, len=5 -> seq_out 6,3,1,4,0; done=1 one cycle after 0 is shown; busy falls; seq_idx stays 0.
- Free-run with en toggled 1,0,0,1 -> idx holds for two cycles with no wrap; then stop -> IDLE, idx retained; then start and stop in the same cycle -> stays IDLE.
- len=1, mode=0 -> seq_out constant table[0] and wrap high every enabled cycle. Then write wr_addr=0, wr_data=7 mid-run -> seq_out=7 on the next cycle.
- Assert rst=0 asynchronously mid-run -> outputs return to reset values immediately and table reverts to the identity pattern (seq_out=0).

Source files
------------

// File: rtl/seq_table_fsm.sv
// ---------------------------------------------------------------------------
// seq_table_fsm
//
// Programmable sequence generator. Instead of walking a hard-coded state
// order, it steps an index through a writable table of WIDTH-bit codes and
// presents table[index] every cycle. Length, direction, enable/pause,
// free-run versus one-shot operation and start/stop control are all
// available at run time.
//
// Ports:
//   clk_i      system clock, all state changes on the rising edge
//   rst_ni     asynchronous active-low reset (restores the identity table)
//   start_i    pulse: begin a run from IDLE, or restart while running
//   stop_i     pulse: abort a run and return to IDLE
//   en_i       step enable while running; 0 holds the current index
//   dir_i      0 = ascending index, 1 = descending index
//   mode_i     0 = free-run (wrap forever), 1 = one-shot; sampled at start
//   len_i      active entries; 0 or > DEPTH means DEPTH; sampled at start
//   wr_en_i    table write strobe
//   wr_addr_i  table write address
//   wr_data_i  table write data
//   seq_out_o  code at the current index (combinational table read)
//   seq_idx_o  current index
//   busy_o     high while running
//   wrap_o     registered one-cycle pulse on each free-run wrap
//   done_o     registered one-cycle pulse on one-shot completion
// ---------------------------------------------------------------------------
module seq_table_fsm #(
  parameter  int WIDTH = 3,
  parameter  int DEPTH = 8,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             mode_i,
  input  logic [IDX_W:0]   len_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  output logic [WIDTH-1:0] seq_out_o,
  output logic [IDX_W-1:0] seq_idx_o,
  output logic             busy_o,
  output logic             wrap_o,
  output logic             done_o
);

  localparam int LEN_W = IDX_W + 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] table_q [DEPTH];

  logic [LEN_W-1:0] len_start;
  logic [IDX_W-1:0] last_idx;
  logic             terminal;
  logic             wr_hit;

  // A length of zero, or one larger than the table, selects the full table.
  assign len_start = ((len_i == '0) || (len_i > LEN_W'(DEPTH))) ? LEN_W'(DEPTH) : len_i;

  // Terminal test uses the live direction, so a mid-run direction change
  // decides both where the next step goes and whether it wraps/finishes.
  assign last_idx = IDX_W'(len_q - LEN_W'(1));
  assign terminal = dir_i ? (idx_q == '0) : (idx_q == last_idx);

  assign wr_hit = wr_en_i && ({1'b0, wr_addr_i} < LEN_W'(DEPTH));

  // Code table. Reset restores the identity pattern; writes are accepted in
  // any state and appear on seq_out_o the cycle after the write edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= WIDTH'(i);
      end
    end else if (wr_hit) begin
      table_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Controller state register, including the pulse outputs so that wrap and
  // done are glitch-free and appear the cycle after the step that caused them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= LEN_W'(DEPTH);
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Priority is stop, then start, then stepping. A stop
  // while idle is ignored, so start and stop together leave an idle
  // sequencer idle. Wrapping is done against the programmed length, not the
  // natural rollover of the index register.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
    end else if (start_i) begin
      state_d = RUN;
      len_d   = len_start;
      mode_d  = mode_i;
      idx_d   = dir_i ? IDX_W'(len_start - LEN_W'(1)) : '0;
    end else if ((state_q == RUN) && en_i) begin
      if (terminal) begin
        if (mode_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d  = dir_i ? last_idx : '0;
          wrap_d = 1'b1;
        end
      end else if (dir_i) begin
        idx_d = idx_q - IDX_W'(1);
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  assign seq_out_o = table_q[idx_q];
  assign seq_idx_o = idx_q;
  assign busy_o    = (state_q == RUN);
  assign wrap_o    = wrap_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_seq_table_fsm.sv
// ---------------------------------------------------------------------------
// tb_seq_table_fsm
//
// Self-checking bench for seq_table_fsm. A behavioural model (integer index,
// length and an array copy of the table) predicts every output after each
// clock edge; directed scenarios additionally pin the model to hand-worked
// literal sequences, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_seq_table_fsm;

  localparam int WIDTH = 3;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rstN;
  logic             start, stop, en, dir, mode, wrEn;
  logic [IDX_W:0]   len;
  logic [IDX_W-1:0] wrAddr;
  logic [WIDTH-1:0] wrData;
  logic [WIDTH-1:0] seqOut;
  logic [IDX_W-1:0] seqIdx;
  logic             busy, wrap, done;

  int vectors     = 0;
  int miscompares = 0;

  // Model state.
  int mTable [DEPTH];
  bit mRun;
  int mIdx;
  int mLen;
  bit mOneShot;
  bit mWrap;
  bit mDone;

  int litFree [8] = '{0, 4, 1, 3, 6, 2, 7, 5};
  int litShot [5] = '{6, 3, 1, 4, 0};

  seq_table_fsm #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i     (clk),
    .rst_ni    (rstN),
    .start_i   (start),
    .stop_i    (stop),
    .en_i      (en),
    .dir_i     (dir),
    .mode_i    (mode),
    .len_i     (len),
    .wr_en_i   (wrEn),
    .wr_addr_i (wrAddr),
    .wr_data_i (wrData),
    .seq_out_o (seqOut),
    .seq_idx_o (seqIdx),
    .busy_o    (busy),
    .wrap_o    (wrap),
    .done_o    (done)
  );

  always #5 clk = ~clk;

  // Reset values of the model: identity table, idle, full length.
  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) mTable[i] = i % (1 << WIDTH);
    mRun     = 1'b0;
    mIdx     = 0;
    mLen     = DEPTH;
    mOneShot = 1'b0;
    mWrap    = 1'b0;
    mDone    = 1'b0;
  endtask

  // Advance the model by one clock edge using the current inputs. A step is
  // taken tentatively; if it leaves the active range [0, len) the run either
  // wraps modulo len or finishes.
  task automatic modelStep();
    int nxt;
    int effLen;
    mWrap = 1'b0;
    mDone = 1'b0;
    if (stop) begin
      mRun = 1'b0;
    end else if (start) begin
      effLen   = (int'(len) == 0 || int'(len) > DEPTH) ? DEPTH : int'(len);
      mLen     = effLen;
      mOneShot = mode;
      mIdx     = dir ? effLen - 1 : 0;
      mRun     = 1'b1;
    end else if (mRun && en) begin
      nxt = dir ? mIdx - 1 : mIdx + 1;
      if (nxt < 0 || nxt >= mLen) begin
        if (mOneShot) begin
          mRun  = 1'b0;
          mDone = 1'b1;
        end else begin
          mIdx  = (nxt + mLen) % mLen;
          mWrap = 1'b1;
        end
      end else begin
        mIdx = nxt;
      end
    end
    if (wrEn && int'(wrAddr) < DEPTH) mTable[wrAddr] = int'(wrData);
  endtask

  task automatic compareField(input string name, input int actual, input int expected);
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic checkOutput();
    vectors++;
    compareField("seq_out", int'(seqOut), mTable[mIdx]);
    compareField("seq_idx", int'(seqIdx), mIdx);
    compareField("busy",    int'(busy),   int'(mRun));
    compareField("wrap",    int'(wrap),   int'(mWrap));
    compareField("done",    int'(done),   int'(mDone));
  endtask

  // Hand-computed expectation, independent of the model.
  task automatic checkLiteral(input string name, input int actual, input int expected);
    vectors++;
    compareField(name, actual, expected);
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input bit e, input bit d,
                               input bit m, input int l, input bit we, input int wa,
                               input int wd);
    start  = st;
    stop   = sp;
    en     = e;
    dir    = d;
    mode   = m;
    len    = (IDX_W+1)'(l);
    wrEn   = we;
    wrAddr = IDX_W'(wa);
    wrData = WIDTH'(wd);
  endtask

  // One clock: predict, let the edge happen, then sample 1 ns later.
  task automatic runCycle();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    #2;
    checkOutput();
    checkLiteral("reset seq_out", int'(seqOut), 0);
    checkLiteral("reset busy", int'(busy), 0);
    #1 rstN = 1'b1;

    // Idle with no stimulus.
    repeat (2) runCycle();

    // Program the table.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1, i, litFree[i]);
      runCycle();
    end

    // Free-run, ascending, full length.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    runCycle();
    checkLiteral("free seq_out", int'(seqOut), litFree[0]);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 10; k++) begin
      runCycle();
      checkLiteral("free seq_out", int'(seqOut), litFree[k % 8]);
      checkLiteral("free wrap", int'(wrap), (k == 8) ? 1 : 0);
      checkLiteral("free busy", int'(busy), 1);
    end

    // One-shot, descending, length 5 (restart from RUN).
    applyStimulus(1, 0, 1, 1, 1, 5, 0, 0, 0);
    runCycle();
    checkLiteral("shot seq_out", int'(seqOut), litShot[0]);
    applyStimulus(0, 0, 1, 1, 1, 5, 0, 0, 0);
    for (int k = 1; k < 5; k++) begin
      runCycle();
      checkLiteral("shot seq_out", int'(seqOut), litShot[k]);
      checkLiteral("shot done", int'(done), 0);
    end
    runCycle();
    checkLiteral("shot done", int'(done), 1);
    checkLiteral("shot busy", int'(busy), 0);
    checkLiteral("shot seq_idx", int'(seqIdx), 0);
    runCycle();
    checkLiteral("shot done clears", int'(done), 0);

    // Free-run with pauses, then stop, then start+stop while idle.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0); runCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0); runCycle();
    checkLiteral("pause seq_idx", int'(seqIdx), 1);
    runCycle();
    checkLiteral("pause seq_idx", int'(seqIdx), 1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0); runCycle();
    checkLiteral("pause resume", int'(seqIdx), 2);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0); runCycle();
    checkLiteral("stop busy", int'(busy), 0);
    checkLiteral("stop seq_idx", int'(seqIdx), 2);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0); runCycle();
    checkLiteral("start+stop busy", int'(busy), 0);

    // Length 1 free-run: wrap every enabled cycle; then overwrite entry 0.
    applyStimulus(1, 0, 1, 0, 0, 1, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      runCycle();
      checkLiteral("len1 wrap", int'(wrap), 1);
      checkLiteral("len1 seq_out", int'(seqOut), 0);
    end
    applyStimulus(0, 0, 1, 0, 0, 1, 1, 0, 7);
    runCycle();
    checkLiteral("len1 write", int'(seqOut), 7);
    applyStimulus(0, 0, 1, 0, 0, 1, 0, 0, 0);
    runCycle();

    // Randomized phase.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0) ? ~dir : dir,
                    $urandom_range(0, 1), $urandom_range(0, 15),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, DEPTH - 1),
                    $urandom_range(0, (1 << WIDTH) - 1));
      runCycle();
    end

    // Asynchronous reset in the middle of a run.
    applyStimulus(1, 0, 1, 0, 0, 0, 1, 0, 5);
    runCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    repeat (3) runCycle();
    #2 rstN = 1'b0;
    #1;
    modelReset();
    checkOutput();
    checkLiteral("async rst seq_out", int'(seqOut), 0);
    checkLiteral("async rst busy", int'(busy), 0);
    rstN = 1'b1;
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 0);
    runCycle();
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 4; k++) begin
      runCycle();
      checkLiteral("identity seq_out", int'(seqOut), k);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
